// File: rtl/pio_core_if.sv
// pio_core_if: AXI4-Lite control-port bundle (32-bit address/data) with master and slave views.
interface pio_core_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/pio_core.sv
// pio_core: AXI4-Lite GPIO block with edge-pending interrupts; PIO_SYNC_EN selects a 2-flop input synchronizer.
module pio_core #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  pio_core_if.slave        t_ctrl,
  output logic             irq0,
  output logic             irq1,
  output logic [WIDTH-1:0] odata,
  output logic [WIDTH-1:0] oenable,
  input  logic [WIDTH-1:0] idata
);
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]       aw_addr_q, aw_addr_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d, rd32;
  logic [WIDTH-1:0] odata_q, odata_d, oen_q, oen_d, rie_q, rie_d, fie_q, fie_d;
  logic [WIDTH-1:0] rip_q, rip_d, fip_q, fip_d, s_q, s_d, sp_q, sp_d;
  logic [WIDTH-1:0] wm, wr, rsel, clr_r, clr_f;
  logic             commit, aw_fire, w_fire, ar_fire;
  logic             unused_ok;
`ifdef PIO_SYNC_EN
  logic [WIDTH-1:0] meta_q;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_wm
    assign wm[i] = w_strb_q[i/8];
  end
  always_comb begin
    commit    = aw_held_q & w_held_q & ~bvalid_q;
    aw_fire   = t_ctrl.awvalid & ~aw_held_q;
    w_fire    = t_ctrl.wvalid & ~w_held_q;
    ar_fire   = t_ctrl.arvalid & ~rvalid_q;
    aw_held_d = aw_fire | (aw_held_q & ~commit);
    aw_addr_d = aw_fire ? t_ctrl.awaddr[4:2] : aw_addr_q;
    w_held_d  = w_fire | (w_held_q & ~commit);
    w_data_d  = w_fire ? t_ctrl.wdata[WIDTH-1:0] : w_data_q;
    w_strb_d  = w_fire ? t_ctrl.wstrb : w_strb_q;
    bvalid_d  = commit | (bvalid_q & ~t_ctrl.bready);
    rsel = t_ctrl.araddr[4:2] == 3'd0 ? odata_q :
           t_ctrl.araddr[4:2] == 3'd1 ? oen_q :
           t_ctrl.araddr[4:2] == 3'd2 ? s_q :
           t_ctrl.araddr[4:2] == 3'd3 ? rie_q :
           t_ctrl.araddr[4:2] == 3'd4 ? fie_q :
           t_ctrl.araddr[4:2] == 3'd5 ? rip_q :
           t_ctrl.araddr[4:2] == 3'd6 ? fip_q : '0;
    rd32 = '0;
    rd32[WIDTH-1:0] = rsel;
    rvalid_d = ar_fire | (rvalid_q & ~t_ctrl.rready);
    rdata_d  = ar_fire ? rd32 : rdata_q;
    wr      = w_data_q & wm;
    odata_d = (commit && aw_addr_q == 3'd0) ? (odata_q & ~wm) | wr : odata_q;
    oen_d   = (commit && aw_addr_q == 3'd1) ? (oen_q & ~wm) | wr : oen_q;
    rie_d   = (commit && aw_addr_q == 3'd3) ? (rie_q & ~wm) | wr : rie_q;
    fie_d   = (commit && aw_addr_q == 3'd4) ? (fie_q & ~wm) | wr : fie_q;
    clr_r   = (commit && aw_addr_q == 3'd5) ? wr : '0;
    clr_f   = (commit && aw_addr_q == 3'd6) ? wr : '0;
    // edge set is OR-ed after the clear so a same-cycle edge wins
    rip_d   = (rip_q & ~clr_r) | (s_q & ~sp_q);
    fip_d   = (fip_q & ~clr_f) | (~s_q & sp_q);
`ifdef PIO_SYNC_EN
    s_d = meta_q;
`else
    s_d = idata;
`endif
    sp_d = s_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      odata_q   <= '0;
      oen_q     <= '0;
      rie_q     <= '0;
      fie_q     <= '0;
      rip_q     <= '0;
      fip_q     <= '0;
      s_q       <= '0;
      sp_q      <= '0;
`ifdef PIO_SYNC_EN
      meta_q    <= '0;
`endif
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      odata_q   <= odata_d;
      oen_q     <= oen_d;
      rie_q     <= rie_d;
      fie_q     <= fie_d;
      rip_q     <= rip_d;
      fip_q     <= fip_d;
      s_q       <= s_d;
      sp_q      <= sp_d;
`ifdef PIO_SYNC_EN
      meta_q    <= idata;
`endif
    end
  end
  assign t_ctrl.awready = ~aw_held_q;
  assign t_ctrl.wready  = ~w_held_q;
  assign t_ctrl.bvalid  = bvalid_q;
  assign t_ctrl.bresp   = 2'b00;
  assign t_ctrl.arready = ~rvalid_q;
  assign t_ctrl.rvalid  = rvalid_q;
  assign t_ctrl.rdata   = rdata_q;
  assign t_ctrl.rresp   = 2'b00;
  assign irq0    = |(rip_q & rie_q);
  assign irq1    = |(fip_q & fie_q);
  assign odata   = odata_q;
  assign oenable = oen_q;
  assign unused_ok = ^{t_ctrl.awaddr[31:5], t_ctrl.awaddr[1:0], t_ctrl.araddr[31:5], t_ctrl.araddr[1:0],
                       t_ctrl.awprot, t_ctrl.arprot, t_ctrl.wdata, w_strb_q};
endmodule

// File: tb/tb_pio_core.sv
// tb_pio_core: directed self-checking bench for pio_core (latency follows PIO_SYNC_EN).
module tb_pio_core;
  localparam int W = 10;
`ifdef PIO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq0, irq1;
  logic [W-1:0] odata, oenable;
  logic [W-1:0] idata = 10'h200;
  int total = 0, bad = 0, bv_pulses = 0;
  logic bv_prev = 1'b0;
  logic [31:0] d;
  pio_core_if bus();
  pio_core #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .t_ctrl(bus), .irq0(irq0), .irq1(irq1),
                             .odata(odata), .oenable(oenable), .idata(idata));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.bvalid && !bv_prev) bv_pulses++;
    bv_prev = bus.bvalid;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
    bus.awvalid = 1; bus.awaddr = a; bus.wvalid = 1; bus.wdata = dat; bus.wstrb = s; bus.bready = 1;
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    for (int k = 0; k < 10 && !bus.bvalid; k++) tick;
    tick;
    bus.bready = 0;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [31:0] r);
    bus.arvalid = 1; bus.araddr = a; bus.rready = 0;
    tick;
    bus.arvalid = 0;
    for (int k = 0; k < 10 && !bus.rvalid; k++) tick;
    r = bus.rvalid ? bus.rdata : 32'hDEAD_BEEF;
    bus.rready = 1;
    tick;
    bus.rready = 0;
  endtask
  task automatic test_reset;
    repeat (3) tick;
    total++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq0, irq1} !== 7'b1110000) begin
      bad++; $display("FAIL reset_handshake got=%b exp=1110000", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq0, irq1}); end
    total++; if ({odata, oenable} !== 20'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {odata, oenable}); end
    reset = 0;
    tick;
  endtask
  task automatic test_write_odata;
    bus.awvalid = 1; bus.awaddr = 32'h0;
    tick;
    bus.awvalid = 0;
    total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL aw_held got=%b exp=0", bus.awready); end
    bus.wvalid = 1; bus.wdata = 32'h5555_5555; bus.wstrb = 4'h5;
    tick;
    bus.wvalid = 0;
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL commit_cycle_bvalid got=%b exp=0", bus.bvalid); end
    tick;
    total++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin bad++; $display("FAIL odata_bresp got=%b exp=100", {bus.bvalid, bus.bresp}); end
    total++; if (odata !== 10'h055) begin bad++; $display("FAIL odata_strobe got=%h exp=055", odata); end
    bus.bready = 1;
    tick;
    bus.bready = 0;
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL bvalid_drop got=%b exp=0", bus.bvalid); end
  endtask
  task automatic test_read;
    bus.arvalid = 1; bus.araddr = 32'h0; bus.rready = 0;
    tick;
    bus.arvalid = 0;
    total++; if ({bus.rvalid, bus.arready, bus.rdata} !== {2'b10, 32'h55}) begin
      bad++; $display("FAIL read_first got=%b/%b/%h exp=1/0/00000055", bus.rvalid, bus.arready, bus.rdata); end
    tick; tick;
    total++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h55}) begin
      bad++; $display("FAIL read_hold got=%b/%h exp=1/00000055", bus.rvalid, bus.rdata); end
    bus.rready = 1;
    tick;
    bus.rready = 0;
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%b exp=0", bus.rvalid); end
  endtask
  task automatic test_oenable_same_cycle;
    bus.awvalid = 1; bus.awaddr = 32'h4; bus.wvalid = 1; bus.wdata = 32'h3FF; bus.wstrb = 4'hF;
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL oen_commit_bvalid got=%b exp=0", bus.bvalid); end
    tick;
    total++; if ({bus.bvalid, oenable} !== {1'b1, 10'h3FF}) begin
      bad++; $display("FAIL oenable_write got=%b/%h exp=1/3ff", bus.bvalid, oenable); end
    bus.bready = 1;
    tick;
    bus.bready = 0;
  endtask
  task automatic test_strobe_unmapped;
    do_write(32'h0, 32'hFFFF_FF00, 4'h2);
    total++; if (odata !== 10'h355) begin bad++; $display("FAIL lane1_strobe got=%h exp=355", odata); end
    do_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    do_read(32'h1C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
    do_write(32'h0, 32'hFFFF_FFFF, 4'hF);
    do_read(32'h0, d);
    total++; if (d !== 32'h3FF) begin bad++; $display("FAIL upper_bits_zero got=%h exp=000003ff", d); end
  endtask
  task automatic test_rise;
    do_read(32'h14, d);
    total++; if (d !== 32'h200) begin bad++; $display("FAIL rip_high_through_reset got=%h exp=200", d); end
    do_write(32'h14, 32'h200, 4'h1);
    do_read(32'h14, d);
    total++; if (d !== 32'h200) begin bad++; $display("FAIL w1c_unstrobed got=%h exp=200", d); end
    do_write(32'h14, 32'h200, 4'h2);
    do_read(32'h14, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_strobed got=%h exp=0", d); end
    do_write(32'h0C, 32'h1, 4'hF);
    idata[0] = 1'b1;
    repeat (LAT - 1) tick;
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL irq0_early got=%b exp=0", irq0); end
    tick;
    total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL irq0_rise got=%b exp=1", irq0); end
    do_write(32'h14, 32'h1, 4'hF);
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL irq0_cleared got=%b exp=0", irq0); end
  endtask
  task automatic test_fall;
    do_write(32'h10, 32'h200, 4'hF);
    idata[9] = 1'b0;
    repeat (LAT - 1) tick;
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq1_early got=%b exp=0", irq1); end
    tick;
    total++; if ({irq1, irq0} !== 2'b10) begin bad++; $display("FAIL irq1_fall got=%b exp=10", {irq1, irq0}); end
    do_read(32'h08, d);
    total++; if (d !== 32'h001) begin bad++; $display("FAIL idata_read got=%h exp=001", d); end
    do_read(32'h18, d);
    total++; if (d !== 32'h200) begin bad++; $display("FAIL fip_read got=%h exp=200", d); end
  endtask
  task automatic test_set_beats_clear;
`ifdef PIO_SYNC_EN
    idata[1] = 1'b1;
    tick;
`endif
    idata[1] = 1'b1;
    bus.awvalid = 1; bus.awaddr = 32'h14; bus.wvalid = 1; bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.bready = 1;
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    for (int k = 0; k < 10 && !bus.bvalid; k++) tick;
    tick;
    bus.bready = 0;
    do_read(32'h14, d);
    total++; if (d !== 32'h002) begin bad++; $display("FAIL set_beats_clear got=%h exp=002", d); end
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = bv_pulses;
    bus.awvalid = 1; bus.awaddr = 32'h0; bus.wvalid = 1; bus.wdata = 32'h0AA; bus.wstrb = 4'hF; bus.bready = 0;
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    tick;
    total++; if ({bus.bvalid, odata} !== {1'b1, 10'h0AA}) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/0aa", bus.bvalid, odata); end
    bus.awvalid = 1; bus.awaddr = 32'h4; bus.wvalid = 1; bus.wdata = 32'h0F0; bus.wstrb = 4'hF;
    tick;
    bus.awvalid = 0; bus.wvalid = 0;
    tick; tick;
    total++; if ({bus.awready, bus.wready, bus.bvalid, oenable} !== {3'b001, 10'h3FF}) begin
      bad++; $display("FAIL b2b_stall got=%b/%h exp=001/3ff", {bus.awready, bus.wready, bus.bvalid}, oenable); end
    bus.bready = 1;
    tick;
    total++; if ({bus.bvalid, oenable} !== {1'b0, 10'h3FF}) begin bad++; $display("FAIL b2b_gap got=%b/%h exp=0/3ff", bus.bvalid, oenable); end
    tick;
    total++; if ({bus.bvalid, oenable} !== {1'b1, 10'h0F0}) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/0f0", bus.bvalid, oenable); end
    tick;
    bus.bready = 0;
    tick;
    total++; if (bv_pulses - n0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", bv_pulses - n0); end
  endtask
  task automatic test_reset_mid;
    bus.awvalid = 1; bus.awaddr = 32'h0; bus.wvalid = 1; bus.wdata = 32'h123; bus.wstrb = 4'hF; bus.bready = 0;
    bus.arvalid = 1; bus.araddr = 32'h4; bus.rready = 0;
    tick;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    tick;
    total++; if ({bus.bvalid, bus.rvalid, odata} !== {2'b11, 10'h123}) begin
      bad++; $display("FAIL mid_setup got=%b/%h exp=11/123", {bus.bvalid, bus.rvalid}, odata); end
    reset = 1;
    #1;
    total++; if ({bus.bvalid, bus.rvalid, odata} !== 12'h0) begin
      bad++; $display("FAIL mid_reset got=%b/%h exp=00/000", {bus.bvalid, bus.rvalid}, odata); end
    tick;
    reset = 0;
    tick;
  endtask
  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    test_reset;
    test_write_odata;
    test_read;
    test_oenable_same_cycle;
    test_strobe_unmapped;
    test_rise;
    test_fall;
    test_set_beats_clear;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
